// File: rtl/sync_ram_pkg.sv
// Shared types and defaults for the clocked data memory.
// Imported by the storage array and the top-level controller.
package sync_ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 9;
   localparam int unsigned DEF_DEPTH  = 256;

   function automatic int unsigned be_count(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sync_ram_array.sv
// Word storage with byte-enable write port and registered read port.
// The array itself is never reset; the controller clears it by writing.
module sync_ram_array
   import sync_ram_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned IDX_W  = 8
) (
   input  logic                          clk,
   input  logic                          we_i,
   input  logic [IDX_W-1:0]              waddr_i,
   input  logic [DATA_W-1:0]             wdata_i,
   input  logic [be_count(DATA_W)-1:0]   wbe_i,
   input  logic                          re_i,
   input  logic [IDX_W-1:0]              raddr_i,
   output logic [DATA_W-1:0]             rdata_o
);

   localparam int unsigned BE_W = be_count(DATA_W);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (wbe_i[i]) begin
               mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_ram.sv
// Clocked single-port data memory: post-reset clear sequence, ready handshake,
// registered read with valid strobe, and sticky conflict/range error flags.
module sync_ram
   import sync_ram_pkg::*;
#(
   parameter int unsigned       DATA_W         = DEF_DATA_W,
   parameter int unsigned       ADDR_W         = DEF_ADDR_W,
   parameter int unsigned       DEPTH          = DEF_DEPTH,
   parameter bit                CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          read,
   input  logic                          write,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [DATA_W-1:0]             wdata,
   input  logic [be_count(DATA_W)-1:0]   be,
   output logic [DATA_W-1:0]             rdata,
   output logic                          rvalid,
   output logic                          ready,
   output logic                          err_rw,
   output logic                          err_addr,
   input  logic                          err_clr
);

   localparam int unsigned       BE_W     = be_count(DATA_W);
   localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
   localparam state_e            RESET_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic              ready_q, ready_d;
   logic              rvalid_q, rvalid_d;
   logic              zero_q, zero_d;
   logic              err_rw_q, err_rw_d;
   logic              err_addr_q, err_addr_d;

   logic              clr_we;
   logic              in_range;
   logic              conflict;
   logic              bad_addr;
   logic              do_rd;
   logic              acc_we;
   logic              arr_we;
   logic              arr_re;
   logic [IDX_W-1:0]  arr_waddr;
   logic [DATA_W-1:0] arr_wdata;
   logic [BE_W-1:0]   arr_wbe;
   logic [DATA_W-1:0] arr_rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RESET_ST;
         clr_cnt_q  <= '0;
         ready_q    <= 1'b0;
         rvalid_q   <= 1'b0;
         zero_q     <= 1'b1;
         err_rw_q   <= 1'b0;
         err_addr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         ready_q    <= ready_d;
         rvalid_q   <= rvalid_d;
         zero_q     <= zero_d;
         err_rw_q   <= err_rw_d;
         err_addr_q <= err_addr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we    = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            clr_we = 1'b1;
            if (clr_cnt_q == LAST_IDX) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = RESET_ST;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // Accesses are gated by the registered ready, so nothing is accepted in the
   // cycle immediately after reset even when the clear sequence is skipped.
   always_comb begin
      in_range = ({1'b0, addr} < DEPTH_C);
      conflict = ready_q & read & write;
      bad_addr = ready_q & (read | write) & ~in_range;
      do_rd    = ready_q & read & ~write;
      arr_re   = do_rd & in_range;
      acc_we   = ready_q & write & ~read & in_range;

      rvalid_d   = do_rd;
      zero_d     = do_rd ? ~in_range : zero_q;
      err_rw_d   = conflict | (err_rw_q & ~err_clr);
      err_addr_d = bad_addr | (err_addr_q & ~err_clr);
   end

   always_comb begin
      arr_we    = clr_we | acc_we;
      arr_waddr = addr[IDX_W-1:0];
      arr_wdata = wdata;
      arr_wbe   = be;
      if (clr_we) begin
         arr_waddr = clr_cnt_q;
         arr_wdata = CLEAR_VAL;
         arr_wbe   = '1;
      end
   end

   sync_ram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .waddr_i (arr_waddr),
      .wdata_i (arr_wdata),
      .wbe_i   (arr_wbe),
      .re_i    (arr_re),
      .raddr_i (addr[IDX_W-1:0]),
      .rdata_o (arr_rdata)
   );

   // The array's read register is not reset; zero_q masks it after reset and
   // after out-of-range reads, and holds across cycles without a read.
   assign rdata    = zero_q ? '0 : arr_rdata;
   assign rvalid   = rvalid_q;
   assign ready    = ready_q;
   assign err_rw   = err_rw_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_sync_ram.sv
// Directed, table-driven self-checking bench for sync_ram (default parameters).
module tb_sync_ram;

   logic        clk = 1'b0;
   logic        reset;
   logic        read, write, err_clr;
   logic [8:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        rvalid, ready, err_rw, err_addr;

   int errors = 0;
   int checks = 0;
   logic side;

   always #5 clk = ~clk;

   sync_ram #(
      .DATA_W         (32),
      .ADDR_W         (9),
      .DEPTH          (256),
      .CLEAR_ON_RESET (1'b1),
      .CLEAR_VAL      (32'h0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .read     (read),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .be       (be),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .ready    (ready),
      .err_rw   (err_rw),
      .err_addr (err_addr),
      .err_clr  (err_clr)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic        clr;
      logic [8:0]  a;
      logic [31:0] d;
      logic [3:0]  b;
      logic        e_rv;
      logic [31:0] e_rd;
      logic        e_rw;
      logic        e_ad;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic rd, input logic wr, input logic clr,
                               input logic [8:0] a, input logic [31:0] d,
                               input logic [3:0] b, input logic e_rv,
                               input logic [31:0] e_rd, input logic e_rw,
                               input logic e_ad);
      vec_t v;
      v.rd = rd; v.wr = wr; v.clr = clr; v.a = a; v.d = d; v.b = b;
      v.e_rv = e_rv; v.e_rd = e_rd; v.e_rw = e_rw; v.e_ad = e_ad;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      read = 1'b0; write = 1'b0; err_clr = 1'b0;
      addr = '0; wdata = '0; be = '0;
   endtask

   // Called just after reset release; counts cycles with ready low, bounded.
   task automatic wait_ready(output int n);
      n = 0;
      side = 1'b0;
      while (ready !== 1'b1 && n < 1000) begin
         n++;
         @(posedge clk);
         #1;
         if (rvalid === 1'b1 || err_rw === 1'b1 || err_addr === 1'b1) side = 1'b1;
      end
   endtask

   task automatic single_read(input string name, input logic [8:0] a, input logic [31:0] exp);
      @(negedge clk);
      idle_inputs();
      read = 1'b1; addr = a;
      @(posedge clk);
      #1;
      chk({name, " rvalid"}, {31'd0, rvalid}, 32'd1);
      chk({name, " rdata"}, rdata, exp);
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      int n;

      tv.push_back(mk(1,0,0,  9'd0, 32'h0,        4'h0, 1, 32'h00000000, 0, 0));
      tv.push_back(mk(1,0,0, 9'd85, 32'h0,        4'h0, 1, 32'h00000000, 0, 0));
      tv.push_back(mk(1,0,0,9'd255, 32'h0,        4'h0, 1, 32'h00000000, 0, 0));
      tv.push_back(mk(0,1,0,  9'd0, 32'h00800055, 4'hF, 0, 32'h00000000, 0, 0));
      tv.push_back(mk(1,0,0,  9'd0, 32'h0,        4'h0, 1, 32'h00800055, 0, 0));
      tv.push_back(mk(0,0,0,  9'd0, 32'h0,        4'h0, 0, 32'h00800055, 0, 0));
      tv.push_back(mk(0,1,0, 9'd85, 32'h00000002, 4'hF, 0, 32'h00800055, 0, 0));
      tv.push_back(mk(0,1,0, 9'd85, 32'hAABBCCDD, 4'h5, 0, 32'h00800055, 0, 0));
      tv.push_back(mk(1,0,0, 9'd85, 32'h0,        4'h0, 1, 32'h00BB00DD, 0, 0));
      tv.push_back(mk(0,1,0, 9'd10, 32'h12345678, 4'hF, 0, 32'h00BB00DD, 0, 0));
      tv.push_back(mk(1,1,0, 9'd10, 32'hFFFFFFFF, 4'hF, 0, 32'h00BB00DD, 1, 0));
      tv.push_back(mk(1,0,0, 9'd10, 32'h0,        4'h0, 1, 32'h12345678, 1, 0));
      tv.push_back(mk(0,0,1,  9'd0, 32'h0,        4'h0, 0, 32'h12345678, 0, 0));
      tv.push_back(mk(1,0,0,9'd300, 32'h0,        4'h0, 1, 32'h00000000, 0, 1));
      tv.push_back(mk(0,1,0,9'd255, 32'hCAFEF00D, 4'hF, 0, 32'h00000000, 0, 1));
      tv.push_back(mk(0,1,0,9'd511, 32'hDEADBEEF, 4'hF, 0, 32'h00000000, 0, 1));
      tv.push_back(mk(1,0,0,9'd255, 32'h0,        4'h0, 1, 32'hCAFEF00D, 0, 1));
      tv.push_back(mk(0,0,1,  9'd0, 32'h0,        4'h0, 0, 32'hCAFEF00D, 0, 0));
      tv.push_back(mk(0,1,1,9'd400, 32'h11111111, 4'hF, 0, 32'hCAFEF00D, 0, 1));
      tv.push_back(mk(1,1,0,9'd300, 32'h22222222, 4'hF, 0, 32'hCAFEF00D, 1, 1));
      tv.push_back(mk(0,0,1,  9'd0, 32'h0,        4'h0, 0, 32'hCAFEF00D, 0, 0));
      tv.push_back(mk(0,1,0, 9'd85, 32'hFFFFFFFF, 4'h0, 0, 32'hCAFEF00D, 0, 0));
      tv.push_back(mk(1,0,0, 9'd85, 32'h0,        4'h0, 1, 32'h00BB00DD, 0, 0));
      tv.push_back(mk(1,0,0,  9'd0, 32'h0,        4'h0, 1, 32'h00800055, 0, 0));
      tv.push_back(mk(1,0,0, 9'd10, 32'h0,        4'h0, 1, 32'h12345678, 0, 0));
      tv.push_back(mk(1,0,0,9'd300, 32'h0,        4'h0, 1, 32'h00000000, 0, 1));

      idle_inputs();
      reset = 1'b1;
      #12;
      chk("reset rdata",    rdata,              32'd0);
      chk("reset rvalid",   {31'd0, rvalid},    32'd0);
      chk("reset ready",    {31'd0, ready},     32'd0);
      chk("reset err_rw",   {31'd0, err_rw},    32'd0);
      chk("reset err_addr", {31'd0, err_addr},  32'd0);

      // Conflicting, out-of-range requests held through the clear must be ignored.
      @(negedge clk);
      reset = 1'b0;
      read = 1'b1; write = 1'b1; addr = 9'd300; wdata = 32'hFFFFFFFF; be = 4'hF;
      wait_ready(n);
      idle_inputs();
      chk("clear ready-low cycles", n, 32'd256);
      chk("clear ignores access", {31'd0, side}, 32'd0);

      foreach (tv[i]) begin
         @(negedge clk);
         read = tv[i].rd; write = tv[i].wr; err_clr = tv[i].clr;
         addr = tv[i].a; wdata = tv[i].d; be = tv[i].b;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d rvalid", i),   {31'd0, rvalid},   {31'd0, tv[i].e_rv});
         chk($sformatf("v%0d rdata", i),    rdata,             tv[i].e_rd);
         chk($sformatf("v%0d err_rw", i),   {31'd0, err_rw},   {31'd0, tv[i].e_rw});
         chk($sformatf("v%0d err_addr", i), {31'd0, err_addr}, {31'd0, tv[i].e_ad});
         chk($sformatf("v%0d ready", i),    {31'd0, ready},    32'd1);
      end
      @(negedge clk);
      idle_inputs();
      @(posedge clk);
      #1;
      chk("rvalid single pulse", {31'd0, rvalid}, 32'd0);

      // Reset again, then interrupt the clear at cycle 100 for two cycles.
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst2 ready", {31'd0, ready}, 32'd0);
      chk("rst2 err_addr", {31'd0, err_addr}, 32'd0);
      chk("rst2 rdata", rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      chk("mid-clear ready", {31'd0, ready}, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_ready(n);
      chk("restart ready-low cycles", n, 32'd256);
      single_read("post-clear addr0", 9'd0, 32'h00000000);
      single_read("post-clear addr85", 9'd85, 32'h00000000);
      single_read("post-clear addr255", 9'd255, 32'h00000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_ram.md
Name: sync_ram

Overview:
Parametrised, clocked single-port data memory. It replaces the combinational, unclocked lab RAM in the processor datapath. Adds:
- split write/read data buses, with byte-enables
- registered read with a valid strobe
- post-reset memory clear sequence with a ready handshake
- sticky error flags for conflicting or out-of-range accesses

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
ADDR_W, 9, address port width
DEPTH, 256, number of implemented words; must be at most 2**ADDR_W
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset before accepting accesses
CLEAR_VAL, 0, word value written to every location during the clear sequence

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
read  in  1  read request, sampled at the rising edge
write  in  1  write request, sampled at the rising edge
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
be  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i]
rdata  out  DATA_W  registered read data
rvalid  out  1  one-cycle strobe marking rdata valid
ready  out  1  high when accesses are accepted
err_rw  out  1  sticky: read and write were asserted together
err_addr  out  1  sticky: an access had addr >= DEPTH
err_clr  in  1  synchronous clear of both error flags

Behaviour:
- Reset values: rdata=0, rvalid=0, ready=0, err_rw=0, err_addr=0, FSM state=CLEAR (or IDLE if CLEAR_ON_RESET=0), clr_cnt=0.
- Array contents are not reset asynchronously; they are cleared only by the CLEAR state.
- FSM has two states:
  - CLEAR: each cycle write CLEAR_VAL to mem[clr_cnt], then clr_cnt++. When clr_cnt==DEPTH-1 has been written, go to IDLE. Takes DEPTH cycles. ready=0 throughout. read/write are ignored: no access, no error flags, no rvalid.
  - IDLE: ready=1. No exit other than reset.
- CLEAR_ON_RESET=0: FSM enters IDLE directly; ready=1 in the first cycle after reset deasserts.
- Reset asserted mid-CLEAR: returns immediately to the reset values and restarts the clear from address 0.
- Write (IDLE, write=1, read=0, addr<DEPTH): at the edge, mem[addr] byte i is updated only where be[i]=1. be=0 is a legal no-op.
- Read (IDLE, read=1, write=0, addr<DEPTH): at the edge, rdata<=mem[addr] and rvalid<=1. Latency 1 cycle.
- Back-to-back reads: one result per cycle.
- rdata holds its last value while rvalid=0.
- Read-after-write, same address, next cycle: returns the newly written data. There is no same-cycle hazard because read and write are exclusive.
- read=1 and write=1 together (IDLE): no array access, no rvalid. err_rw<=1.
- addr >= DEPTH with read or write (IDLE): no array access. err_addr<=1. A read still produces rvalid=1 with rdata=0 so requesters never stall.
- Conflict and range errors in the same cycle: both flags set.
- Error flags stay set until err_clr=1 or reset.
- err_clr=1 in the same cycle as a new error: the new error wins (flag stays/ends at 1).
- Address compare is unsigned over ADDR_W bits. Only the low clog2(DEPTH) bits index the array.

Decomposition:
- Package sync_ram_pkg:
  - state enum {CLEAR, IDLE}
  - default DATA_W/ADDR_W/DEPTH constants
  - function computing the byte-enable count
- Sub-module sync_ram_array:
  - contents: storage, byte-enable write, registered read port
  - single write and single read port
  - behaviour: no reset on the memory array itself
- Top level holds the FSM, clear counter, access arbitration, error flags and the out-of-range rdata mux.

Test Plan:
- Reset, CLEAR_ON_RESET=1, DEPTH=256 -> ready=0 for exactly 256 cycles, then 1; reads of addr 0, 85, 255 each return 0x00000000 with rvalid one cycle later.
- Write addr 0 = 0x00800055, be=4'hF, then read addr 0 next cycle -> rdata=0x00800055, rvalid=1 for one cycle only.
- Write 0x00000002 to addr 85 with be=4'hF, then write 0xAABBCCDD with be=4'b0101, then read -> rdata=0x00BB00DD.
- read=1 and write=1 at addr 10 holding 0x12345678 -> err_rw=1, rvalid=0, addr 10 still reads 0x12345678; pulse err_clr -> err_rw=0.
- Read addr 300 -> err_addr=1, rvalid=1, rdata=0; write addr 511 -> no change to addr 255 (addr 511 = 255 in the low index bits).
- Assert reset at clear cycle 100 for 2 cycles -> ready stays 0 for a full 256 cycles after release; previously written addr 0 reads 0.
